// File: rtl/darkriscv_dbus_arbiter_pkg.sv
// Shared types and helpers for the darkriscv data-bus arbiter:
// FSM states, DLEN codes, byte-enable and legality functions.
package darkriscv_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERRC = 2'd2
  } state_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;
  // 8 does not fit the 3-bit field; a dword wraps to 0
  localparam logic [2:0] LEN_D = 3'd0;

  function automatic logic [3:0] len_bytes(
    input logic [2:0] dlen
  );
    return (dlen == LEN_D) ? 4'd8 : {1'b0, dlen};
  endfunction

  function automatic logic [7:0] be_from_len(
    input logic [2:0] dlen,
    input logic [2:0] off
  );
    logic [8:0] m;
    m = (9'd1 << len_bytes(dlen)) - 9'd1;
    return m[7:0] << off;
  endfunction

  function automatic logic is_legal(
    input logic [2:0] dlen,
    input logic [2:0] addr,
    input logic       rd,
    input logic       wr,
    input logic       dw64
  );
    logic ok_len;
    logic ok_al;
    ok_len = 1'b1;
    ok_al  = 1'b1;
    case (dlen)
      LEN_B: ok_al = 1'b1;
      LEN_H: ok_al = ~addr[0];
      LEN_W: ok_al = (addr[1:0] == 2'b00);
      LEN_D: begin
        ok_len = dw64;
        ok_al  = (addr == 3'b000);
      end
      default: begin
        ok_len = 1'b0;
        ok_al  = 1'b0;
      end
    endcase
    return ok_len & ok_al & (rd ^ wr);
  endfunction

endpackage

// File: rtl/darkriscv_dbus_arbiter_if.sv
// Data-bus bundle: NM request ports plus the shared slave port.
// master = requesters and memory side, slave = the arbiter.
interface darkriscv_dbus_if #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int NB = DW / 8;

  logic [NM-1:0]    m_das;
  logic [NM-1:0]    m_drd;
  logic [NM-1:0]    m_dwr;
  logic [NM*3-1:0]  m_dlen;
  logic [NM*AW-1:0] m_daddr;
  logic [NM*DW-1:0] m_datao;
  logic [NM*DW-1:0] m_datai;
  logic [NM-1:0]    m_hlt;
  logic [NM-1:0]    m_err;
  logic             s_das;
  logic             s_drd;
  logic             s_dwr;
  logic [AW-1:0]    s_daddr;
  logic [DW-1:0]    s_datao;
  logic [NB-1:0]    s_be;
  logic [DW-1:0]    s_datai;
  logic             s_ack;

  modport master (
    output m_das, m_drd, m_dwr, m_dlen,
    output m_daddr, m_datao,
    output s_datai, s_ack,
    input  m_datai, m_hlt, m_err,
    input  s_das, s_drd, s_dwr,
    input  s_daddr, s_datao, s_be
  );

  modport slave (
    input  m_das, m_drd, m_dwr, m_dlen,
    input  m_daddr, m_datao,
    input  s_datai, s_ack,
    output m_datai, m_hlt, m_err,
    output s_das, s_drd, s_dwr,
    output s_daddr, s_datao, s_be
  );

endinterface

// File: rtl/darkriscv_dbus_arbiter_rr.sv
// Combinational round-robin picker: search starts at ptr+1.
// Ports: req in, ptr in; gnt one-hot out, idx out.
module darkriscv_rr_arbiter #(
  parameter int NM = 2,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NM-1:0] gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NM; k++) begin
      j = (int'(ptr) + k) % NM;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/darkriscv_dbus_arbiter.sv
// N-master to 1-slave data-bus arbiter with round-robin grant.
// Ports: clk, res (sync, high), bus (slave modport).
import darkriscv_dbus_pkg::*;

module darkriscv_dbus_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             res,
  darkriscv_dbus_if.slave bus
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic DW64 = (DW == 64);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [NM-1:0] gnt_q;
  logic          rd_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dato_q;
  logic [NB-1:0] be_q;
  logic [CW-1:0] cnt;

  logic [NM-1:0] gnt;
  logic [IW-1:0] idx;

  darkriscv_rr_arbiter #(
    .NM(NM),
    .IW(IW)
  ) u_rr (
    .req(bus.m_das),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx)
  );

  logic [2:0]    sel_len;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_dato;
  logic          sel_rd;
  logic          sel_wr;
  logic [2:0]    sel_off;
  logic [NB-1:0] sel_be;
  logic          sel_ok;

  always_comb begin
    sel_len  = bus.m_dlen[int'(idx)*3 +: 3];
    sel_addr = bus.m_daddr[int'(idx)*AW +: AW];
    sel_dato = bus.m_datao[int'(idx)*DW +: DW];
    sel_rd   = bus.m_drd[idx];
    sel_wr   = bus.m_dwr[idx];
    sel_off  = 3'(sel_addr[OW-1:0]);
    sel_be   = NB'(be_from_len(sel_len, sel_off));
    sel_ok   = is_legal(sel_len, 3'(sel_addr),
                        sel_rd, sel_wr, DW64);
  end

  logic busy;
  logic errc;
  logic ack;
  logic tmo;
  logic done;
  logic fail;

  assign busy = (state == BUSY);
  assign errc = (state == ERRC);
  assign ack  = busy & bus.s_ack;
  assign tmo  = busy & (TIMEOUT != 0) & (cnt == TLAST);
  assign done = ack | tmo | errc;
  // an ack arriving with the timeout still counts as success
  assign fail = errc | (tmo & ~bus.s_ack);

  assign bus.s_das   = busy;
  assign bus.s_drd   = busy & rd_q;
  assign bus.s_dwr   = busy & wr_q;
  assign bus.s_be    = busy ? be_q : '0;
  assign bus.s_daddr = addr_q;
  assign bus.s_datao = dato_q;

  // a master that dropped its strobe gets neither data nor error
  assign bus.m_hlt = bus.m_das & ~(gnt_q & {NM{done}});
  assign bus.m_err = gnt_q & bus.m_das & {NM{fail}};

  always_comb begin
    bus.m_datai = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q[i] & bus.m_das[i] & ack & rd_q)
        bus.m_datai[i*DW +: DW] = bus.s_datai;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state  <= IDLE;
      ptr    <= IW'(NM - 1);
      gnt_q  <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      dato_q <= '0;
      be_q   <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.m_das) begin
            gnt_q  <= gnt;
            ptr    <= idx;
            rd_q   <= sel_rd;
            wr_q   <= sel_wr;
            addr_q <= sel_addr;
            dato_q <= sel_dato;
            be_q   <= sel_be;
            cnt    <= '0;
            state  <= sel_ok ? BUSY : ERRC;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (done) state <= IDLE;
        end
        ERRC: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
